// File: rtl/hs_fifo_pkg.sv
// Shared FIFO-side types for the hs_fifo_* blocks.
// Provides the packet-reader FSM state enum.
package hs_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/hs_ifr_misc_typedefs_pkg.sv
// Shared miscellaneous typedefs for the hs_* blocks.
// Provides bool_e, a two-valued boolean enum.
package hs_ifr_misc_typedefs_pkg;

    typedef enum logic {
        FALSE = 1'b0,
        TRUE  = 1'b1
    } bool_e;

endpackage

// File: rtl/hs_fifo_pkt_rd_sva.sv
// Assertion mirror for hs_fifo_pkt_rd, bound into every instance.
// Ports: clk/aresetn, FSM state and beat count, handshake and pulses.
module hs_fifo_pkt_rd_sva
    import hs_fifo_pkg::*;
#(
    parameter int MAX_PKT_LEN = 256,
    localparam int LEN_WIDTH = $clog2(MAX_PKT_LEN + 1)
) (
    input logic                 clk,
    input logic                 aresetn,
    input state_e               state,
    input logic [LEN_WIDTH-1:0] cnt,
    input logic                 rvalid,
    input logic                 rready,
    input logic                 rlast,
    input logic                 m_valid,
    input logic                 err_oversize,
    input logic                 pkt_done
);

    localparam logic [LEN_WIDTH-1:0] LP_MAX =
        LEN_WIDTH'(MAX_PKT_LEN);

    a_flush_drains: assert property (
        @(posedge clk) disable iff (!aresetn)
        (state == FLUSH) |-> (rready && !m_valid)
    );

    a_err_in_flush: assert property (
        @(posedge clk) disable iff (!aresetn)
        err_oversize |-> (state == FLUSH)
    );

    a_done_after_last: assert property (
        @(posedge clk) disable iff (!aresetn)
        (rvalid && rready && rlast) |=> pkt_done
    );

    a_cnt_range: assert property (
        @(posedge clk) disable iff (!aresetn)
        cnt <= LP_MAX
    );

endmodule

bind hs_fifo_pkt_rd hs_fifo_pkt_rd_sva #(
    .MAX_PKT_LEN(MAX_PKT_LEN)
) u_sva (
    .clk         (clk),
    .aresetn     (aresetn),
    .state       (r_state),
    .cnt         (r_cnt),
    .rvalid      (rvalid),
    .rready      (rready),
    .rlast       (rlast),
    .m_valid     (m_valid),
    .err_oversize(err_oversize),
    .pkt_done    (pkt_done)
);

// File: rtl/hs_fifo_pkt_rd.sv
// Packet reader: zero-latency FIFO-to-stream pass-through that
// tags first/last beats, truncates packets longer than
// MAX_PKT_LEN (flushing the rest) and reports per-packet status.
// Ports: clk, aresetn; FIFO side rvalid/rready/rdata/rlast;
// stream side m_valid/m_ready/m_data/m_first/m_last;
// status pkt_done/pkt_len/err_oversize/pkt_cnt/busy.
module hs_fifo_pkt_rd
    import hs_fifo_pkg::*;
    import hs_ifr_misc_typedefs_pkg::*;
#(
    parameter type DATA_TYPE = logic,
    parameter int MAX_PKT_LEN = 256,
    localparam int LEN_WIDTH = $clog2(MAX_PKT_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic                 rvalid,
    output logic                 rready,
    input  DATA_TYPE             rdata,
    input  logic                 rlast,
    output logic                 m_valid,
    input  logic                 m_ready,
    output DATA_TYPE             m_data,
    output logic                 m_first,
    output logic                 m_last,
    output logic                 pkt_done,
    output logic [LEN_WIDTH-1:0] pkt_len,
    output logic                 err_oversize,
    output logic [31:0]          pkt_cnt,
    output logic                 busy
);

    localparam logic [LEN_WIDTH-1:0] LP_LAST =
        LEN_WIDTH'(MAX_PKT_LEN - 1);
    localparam logic [LEN_WIDTH-1:0] LP_MAX =
        LEN_WIDTH'(MAX_PKT_LEN);

    state_e               r_state;
    logic [LEN_WIDTH-1:0] r_cnt;
    logic                 r_pkt_done;
    logic [LEN_WIDTH-1:0] r_pkt_len;
    logic                 r_err;
    logic [31:0]          r_pkt_cnt;

    logic  w_flush;
    logic  w_at_max;
    bool_e w_acc;

    assign w_flush  = (r_state == FLUSH);
    assign w_at_max = (r_cnt == LP_LAST);

    // FLUSH drains the FIFO regardless of the downstream.
    assign rready  = w_flush ? 1'b1 : m_ready;
    assign m_valid = w_flush ? 1'b0 : rvalid;
    assign m_data  = rdata;
    assign w_acc   = (rvalid && rready) ? TRUE : FALSE;

    assign m_first = !w_flush && (r_cnt == '0);
    assign m_last  = rlast || w_at_max;

    assign pkt_done     = r_pkt_done;
    assign pkt_len      = r_pkt_len;
    assign err_oversize = r_err;
    assign pkt_cnt      = r_pkt_cnt;
    assign busy         = (r_state != IDLE);

    // In FLUSH r_cnt parks at MAX_PKT_LEN, which is also the
    // saturated forwarded length reported at packet end.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_pkt_done <= 1'b0;
            r_pkt_len  <= '0;
            r_err      <= 1'b0;
            r_pkt_cnt  <= '0;
        end else begin
            r_pkt_done <= 1'b0;
            r_err      <= 1'b0;
            if (w_acc == TRUE) begin
                unique case (r_state)
                    IDLE, PASS: begin
                        if (rlast) begin
                            r_state    <= IDLE;
                            r_cnt      <= '0;
                            r_pkt_done <= 1'b1;
                            r_pkt_len  <= r_cnt + 1'b1;
                            r_pkt_cnt  <= r_pkt_cnt + 32'd1;
                        end else if (w_at_max) begin
                            r_state <= FLUSH;
                            r_cnt   <= LP_MAX;
                            r_err   <= 1'b1;
                        end else begin
                            r_state <= PASS;
                            r_cnt   <= r_cnt + 1'b1;
                        end
                    end
                    FLUSH: begin
                        if (rlast) begin
                            r_state    <= IDLE;
                            r_cnt      <= '0;
                            r_pkt_done <= 1'b1;
                            r_pkt_len  <= LP_MAX;
                            r_pkt_cnt  <= r_pkt_cnt + 32'd1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hs_fifo_pkt_rd.sv
// Directed bench for hs_fifo_pkt_rd (MAX_PKT_LEN=4 and =1).
// Inputs change on negedge; outputs sampled 1ns later.
module tb_hs_fifo_pkt_rd;

    logic        clk = 1'b0;
    logic        aresetn;

    logic        rvalid, rlast, m_ready;
    logic [7:0]  rdata, m_data;
    logic        rready, m_valid, m_first, m_last;
    logic        pkt_done, err_oversize, busy;
    logic [2:0]  pkt_len;
    logic [31:0] pkt_cnt;

    logic        rvalid1, rlast1, m_ready1;
    logic [7:0]  rdata1, m_data1;
    logic        rready1, m_valid1, m_first1, m_last1;
    logic        pkt_done1, err1, busy1;
    logic [0:0]  pkt_len1;
    logic [31:0] pkt_cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hs_fifo_pkt_rd #(
        .DATA_TYPE  (logic [7:0]),
        .MAX_PKT_LEN(4)
    ) dut (
        .clk         (clk),
        .aresetn     (aresetn),
        .rvalid      (rvalid),
        .rready      (rready),
        .rdata       (rdata),
        .rlast       (rlast),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_first     (m_first),
        .m_last      (m_last),
        .pkt_done    (pkt_done),
        .pkt_len     (pkt_len),
        .err_oversize(err_oversize),
        .pkt_cnt     (pkt_cnt),
        .busy        (busy)
    );

    hs_fifo_pkt_rd #(
        .DATA_TYPE  (logic [7:0]),
        .MAX_PKT_LEN(1)
    ) dut1 (
        .clk         (clk),
        .aresetn     (aresetn),
        .rvalid      (rvalid1),
        .rready      (rready1),
        .rdata       (rdata1),
        .rlast       (rlast1),
        .m_valid     (m_valid1),
        .m_ready     (m_ready1),
        .m_data      (m_data1),
        .m_first     (m_first1),
        .m_last      (m_last1),
        .pkt_done    (pkt_done1),
        .pkt_len     (pkt_len1),
        .err_oversize(err1),
        .pkt_cnt     (pkt_cnt1),
        .busy        (busy1)
    );

    task automatic test_reset();
        aresetn = 1'b0;
        rvalid = 1'b1; rlast = 1'b0; rdata = 8'h5A;
        m_ready = 1'b0;
        rvalid1 = 1'b0; rlast1 = 1'b0; rdata1 = 8'h00;
        m_ready1 = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({busy, pkt_done, err_oversize} !== 3'b000) begin
            errors++;
            $display("FAIL rst_flags: got %b want 000",
                     {busy, pkt_done, err_oversize});
        end
        checks++;
        if (pkt_cnt !== 32'd0 || pkt_len !== 3'd0) begin
            errors++;
            $display("FAIL rst_cnt: got %0h/%0d want 0/0",
                     pkt_cnt, pkt_len);
        end
        checks++;
        if (rready !== 1'b0 || m_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_pass: got rr=%b mv=%b want 0 1",
                     rready, m_valid);
        end
        @(negedge clk);
        rvalid = 1'b0; m_ready = 1'b1;
        aresetn = 1'b1;
    endtask

    task automatic test_basic();
        logic ef, el;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            rvalid = 1'b1; rdata = 8'(8'hA0 + k);
            rlast = (k == 2);
            #1;
            ef = (k == 0); el = (k == 2);
            checks++;
            if (m_valid !== 1'b1 || m_data !== 8'(8'hA0 + k)
                || m_first !== ef || m_last !== el) begin
                errors++;
                $display("FAIL basic_beat%0d: got v%b d%h f%b l%b want 1 %h %b %b",
                         k, m_valid, m_data, m_first, m_last,
                         8'(8'hA0 + k), ef, el);
            end
            if (k == 1) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_busy: got %b want 1", busy);
                end
            end
        end
        @(negedge clk);
        rvalid = 1'b0; rlast = 1'b0;
        #1;
        checks++;
        if (pkt_done !== 1'b1 || pkt_len !== 3'd3
            || pkt_cnt !== 32'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: got d%b len%0d cnt%0d b%b want 1 3 1 0",
                     pkt_done, pkt_len, pkt_cnt, busy);
        end
        @(negedge clk);
        #1;
        checks++;
        if (pkt_done !== 1'b0) begin
            errors++;
            $display("FAIL basic_pulse: got %b want 0", pkt_done);
        end
    endtask

    task automatic test_oversize();
        int fwd = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            rvalid = 1'b1; rdata = 8'(8'h10 + k);
            rlast = (k == 5);
            m_ready = (k < 4);
            #1;
            if (m_valid && m_ready) fwd++;
            if (k < 4) begin
                checks++;
                if (m_valid !== 1'b1 || m_last !== (k == 3)
                    || err_oversize !== 1'b0) begin
                    errors++;
                    $display("FAIL ovs_beat%0d: got v%b l%b e%b want 1 %b 0",
                             k, m_valid, m_last, err_oversize, k == 3);
                end
            end else begin
                checks++;
                if (m_valid !== 1'b0 || rready !== 1'b1
                    || err_oversize !== (k == 4)) begin
                    errors++;
                    $display("FAIL ovs_flush%0d: got v%b rr%b e%b want 0 1 %b",
                             k, m_valid, rready, err_oversize, k == 4);
                end
            end
        end
        @(negedge clk);
        rvalid = 1'b0; rlast = 1'b0; m_ready = 1'b1;
        #1;
        checks++;
        if (pkt_done !== 1'b1 || pkt_len !== 3'd4
            || pkt_cnt !== 32'd2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ovs_done: got d%b len%0d cnt%0d b%b want 1 4 2 0",
                     pkt_done, pkt_len, pkt_cnt, busy);
        end
        checks++;
        if (fwd != 4) begin
            errors++;
            $display("FAIL ovs_fwd: got %0d want 4", fwd);
        end
    endtask

    task automatic test_exact();
        int errs_seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            rvalid = 1'b1; rdata = 8'(8'h30 + k);
            rlast = (k == 3);
            #1;
            errs_seen += int'(err_oversize);
            if (k == 3) begin
                checks++;
                if (m_last !== 1'b1 || m_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL exact_last: got l%b v%b want 1 1",
                             m_last, m_valid);
                end
            end
        end
        @(negedge clk);
        rvalid = 1'b0; rlast = 1'b0;
        #1;
        errs_seen += int'(err_oversize);
        checks++;
        if (pkt_done !== 1'b1 || pkt_len !== 3'd4
            || pkt_cnt !== 32'd3 || errs_seen != 0) begin
            errors++;
            $display("FAIL exact_done: got d%b len%0d cnt%0d e%0d want 1 4 3 0",
                     pkt_done, pkt_len, pkt_cnt, errs_seen);
        end
    endtask

    task automatic test_back_to_back();
        int lens [10] = '{1, 3, 2, 4, 1, 2, 3, 4, 2, 1};
        logic [7:0] sd [$];
        logic sf [$];
        logic sl [$];
        int idx = 0;
        int dones = 0;
        int cyc = 0;
        for (int p = 0; p < 10; p++)
            for (int b = 0; b < lens[p]; b++) begin
                sd.push_back(8'(sd.size() * 7 + 3));
                sf.push_back(b == 0);
                sl.push_back(b == lens[p] - 1);
            end
        while (idx < sd.size() && cyc < 1000) begin
            @(negedge clk);
            #1;
            dones += int'(pkt_done);
            rvalid = ($urandom_range(0, 3) != 0);
            m_ready = 1'($urandom_range(0, 1));
            rdata = sd[idx]; rlast = sl[idx];
            #1;
            if (m_valid && m_ready) begin
                checks++;
                if (m_data !== sd[idx] || m_first !== sf[idx]
                    || m_last !== sl[idx]) begin
                    errors++;
                    $display("FAIL b2b_beat%0d: got d%h f%b l%b want %h %b %b",
                             idx, m_data, m_first, m_last,
                             sd[idx], sf[idx], sl[idx]);
                end
            end
            if (rvalid && rready) idx++;
            cyc++;
        end
        checks++;
        if (idx != sd.size()) begin
            errors++;
            $display("FAIL b2b_timeout: got %0d beats want %0d",
                     idx, sd.size());
        end
        @(negedge clk);
        rvalid = 1'b0; rlast = 1'b0; m_ready = 1'b1;
        #1;
        dones += int'(pkt_done);
        checks++;
        if (dones != 10 || pkt_cnt !== 32'd13 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done: got n%0d cnt%0d b%b want 10 13 0",
                     dones, pkt_cnt, busy);
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            rvalid = 1'b1; rlast = 1'b0; rdata = 8'(8'h50 + k);
        end
        @(negedge clk);
        rvalid = 1'b0;
        aresetn = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || pkt_done !== 1'b0
            || pkt_cnt !== 32'd0) begin
            errors++;
            $display("FAIL rmid_rst: got b%b d%b cnt%0d want 0 0 0",
                     busy, pkt_done, pkt_cnt);
        end
        @(negedge clk);
        aresetn = 1'b1;
        #1;
        checks++;
        if (pkt_done !== 1'b0) begin
            errors++;
            $display("FAIL rmid_nodone: got %b want 0", pkt_done);
        end
        @(negedge clk);
        rvalid = 1'b1; rlast = 1'b0; rdata = 8'h60;
        #1;
        checks++;
        if (m_first !== 1'b1) begin
            errors++;
            $display("FAIL rmid_first: got %b want 1", m_first);
        end
        @(negedge clk);
        rlast = 1'b1; rdata = 8'h61;
        #1;
        checks++;
        if (m_first !== 1'b0 || m_last !== 1'b1) begin
            errors++;
            $display("FAIL rmid_last: got f%b l%b want 0 1",
                     m_first, m_last);
        end
        @(negedge clk);
        rvalid = 1'b0; rlast = 1'b0;
        #1;
        checks++;
        if (pkt_done !== 1'b1 || pkt_len !== 3'd2
            || pkt_cnt !== 32'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rmid_done: got d%b len%0d cnt%0d b%b want 1 2 1 0",
                     pkt_done, pkt_len, pkt_cnt, busy);
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        force dut.r_pkt_cnt = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.r_pkt_cnt;
        #1;
        checks++;
        if (pkt_cnt !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL wrap_preset: got %h want fffffffe", pkt_cnt);
        end
        @(negedge clk);
        rvalid = 1'b1; rlast = 1'b1; rdata = 8'h71;
        #1;
        checks++;
        if (m_first !== 1'b1 || m_last !== 1'b1) begin
            errors++;
            $display("FAIL wrap_fl: got f%b l%b want 1 1",
                     m_first, m_last);
        end
        @(negedge clk);
        rdata = 8'h72;
        #1;
        checks++;
        if (pkt_done !== 1'b1 || pkt_cnt !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL wrap_max: got d%b cnt%h want 1 ffffffff",
                     pkt_done, pkt_cnt);
        end
        @(negedge clk);
        rvalid = 1'b0; rlast = 1'b0;
        #1;
        checks++;
        if (pkt_done !== 1'b1 || pkt_cnt !== 32'd0
            || pkt_len !== 3'd1) begin
            errors++;
            $display("FAIL wrap_zero: got d%b cnt%h len%0d want 1 0 1",
                     pkt_done, pkt_cnt, pkt_len);
        end
    endtask

    task automatic test_max1();
        @(negedge clk);
        rvalid1 = 1'b1; rlast1 = 1'b0; rdata1 = 8'hA5;
        #1;
        checks++;
        if ({m_valid1, m_first1, m_last1} !== 3'b111
            || m_data1 !== 8'hA5) begin
            errors++;
            $display("FAIL m1_beat: got %b %h want 111 a5",
                     {m_valid1, m_first1, m_last1}, m_data1);
        end
        @(negedge clk);
        rdata1 = 8'hA6;
        #1;
        checks++;
        if (err1 !== 1'b1 || m_valid1 !== 1'b0) begin
            errors++;
            $display("FAIL m1_flush: got e%b v%b want 1 0",
                     err1, m_valid1);
        end
        @(negedge clk);
        rlast1 = 1'b1;
        @(negedge clk);
        rvalid1 = 1'b0; rlast1 = 1'b0;
        #1;
        checks++;
        if (pkt_done1 !== 1'b1 || pkt_len1 !== 1'b1) begin
            errors++;
            $display("FAIL m1_done: got d%b len%0d want 1 1",
                     pkt_done1, pkt_len1);
        end
        @(negedge clk);
        rvalid1 = 1'b1; rlast1 = 1'b1; rdata1 = 8'hB0;
        #1;
        checks++;
        if ({m_valid1, m_first1, m_last1} !== 3'b111) begin
            errors++;
            $display("FAIL m1_single: got %b want 111",
                     {m_valid1, m_first1, m_last1});
        end
        @(negedge clk);
        rvalid1 = 1'b0; rlast1 = 1'b0;
        #1;
        checks++;
        if (pkt_done1 !== 1'b1 || err1 !== 1'b0
            || pkt_cnt1 !== 32'd2) begin
            errors++;
            $display("FAIL m1_single_done: got d%b e%b cnt%0d want 1 0 2",
                     pkt_done1, err1, pkt_cnt1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_oversize();
        test_exact();
        test_back_to_back();
        test_max1();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
